// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction prefetch queue.
//   fetch_state_e     : prefetch FSM states (FETCH, DRAIN)
//   fetch_entry_t     : one queued {PC, instruction} pair, 64 bits
//   NOP_INSTR_DEFAULT : value presented on InstrF while the queue is empty
//   WORD_BYTES        : fetch stride in bytes
//   next_word_pc()    : sequential PC increment with 32-bit wrap-around
// ---------------------------------------------------------------------------
package ifetch_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,   // issuing sequential fetches
      DRAIN = 1'b1    // waiting out a request made stale by a redirect
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0
   localparam int unsigned WORD_BYTES        = 4;

   function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
      return pc + 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
// Instruction-memory handshake. The request holds (with a stable address)
// until the memory answers with IMemReady; read data is valid in that cycle.
//   IMemReq   : fetch request (master -> memory)
//   IMemAddr  : word address of the request (master -> memory)
//   IMemReady : completion strobe (memory -> master)
//   IMemRData : fetched instruction (memory -> master)
// ---------------------------------------------------------------------------
interface ifetch_queue_if;

   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemReady;
   logic [31:0] IMemRData;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemReady,
      input  IMemRData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemReady,
      output IMemRData
   );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry FIFO of {PC, instruction} pairs with a synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full)
//   pop        : advance the head (ignored when empty)
//   clear      : empty the queue; overrides push and pop in the same cycle
//   dout       : head entry (combinational read, meaningful when count != 0)
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  fetch_entry_t            din,
   output fetch_entry_t            dout,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & (count != DEPTH_C) & ~clear;
   assign do_pop  = pop  & (count != '0)      & ~clear;

   // NOTE: storage has no reset; an entry is only read once count says it
   // was written, so resetting it would add logic and buy nothing.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap on their own.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// Instruction prefetch stage in front of the Fetch/Decode boundary. Issues
// sequential word fetches (one outstanding), buffers {PC, instr} pairs and
// presents the head to the datapath. Redirects flush the queue; a request
// already in flight is drained and its data dropped.
//   clk         : clock
//   reset       : asynchronous active-low reset
//   StallF      : hold the head entry (no consume)
//   Redirect    : flush and restart fetching at RedirectPC
//   RedirectPC  : new fetch address, valid with Redirect
//   imem        : instruction-memory handshake (master side)
//   InstrF      : head instruction, NOP_INSTR when empty
//   PCF         : PC of the head entry, fetch PC when empty
//   InstrValidF : head entry valid
// ---------------------------------------------------------------------------
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallF,
   input  logic                 Redirect,
   input  logic [31:0]          RedirectPC,
   ifetch_queue_if.master       imem,
   output logic [31:0]          InstrF,
   output logic [31:0]          PCF,
   output logic                 InstrValidF
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_state_e     state;
   logic [31:0]      fetch_pc;
   logic [31:0]      target_pc;
   logic             req_q;

   logic             rsp_done;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   // A response completes whenever the held request meets IMemReady; it is
   // only kept in FETCH and only when no redirect is flushing this cycle.
   assign rsp_done   = req_q & imem.IMemReady;
   assign push       = (state == FETCH) & rsp_done & ~Redirect;
   assign pop        = InstrValidF & ~StallF & ~Redirect;
   assign push_entry = '{pc: fetch_pc, instr: imem.IMemRData};

   // Occupancy after this edge in the non-redirect case; drives the
   // registered request so IMemReq returns the cycle after a freeing pop.
   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         fetch_pc  <= RESET_PC;
         target_pc <= RESET_PC;
         req_q     <= 1'b0;
      end else if (Redirect) begin
         target_pc <= RedirectPC;
         if (req_q && !imem.IMemReady) begin
            // Memory still owes us a word for the old address: keep the
            // request stable and swallow the answer in DRAIN.
            state <= DRAIN;
            req_q <= 1'b1;
         end else begin
            // Nothing in flight (or it finishes now and is dropped).
            state    <= FETCH;
            fetch_pc <= RedirectPC;
            req_q    <= 1'b1;   // queue is emptied, so there is room
         end
      end else begin
         case (state)
            FETCH: begin
               if (rsp_done) begin
                  fetch_pc <= next_word_pc(fetch_pc);
               end
               // A pending request holds; otherwise issue whenever a slot
               // will be free after this edge.
               req_q <= (req_q & ~imem.IMemReady) | (count_next < DEPTH_C);
            end
            DRAIN: begin
               if (imem.IMemReady) begin
                  state    <= FETCH;
                  fetch_pc <= target_pc;
                  req_q    <= 1'b1;
               end
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .clear (Redirect),
      .din   (push_entry),
      .dout  (head),
      .count (count)
   );

   assign imem.IMemReq  = req_q;
   assign imem.IMemAddr = fetch_pc;

   assign InstrValidF = (count != '0);
   assign InstrF      = InstrValidF ? head.instr : NOP_INSTR;
   assign PCF         = InstrValidF ? head.pc    : fetch_pc;

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch stage directly upstream of the pipelined datapath's Fetch/Decode boundary; sits between instruction memory and the datapath's InstrF input.
- Issues sequential word fetches over a hold-until-ready memory handshake and buffers {PC, instruction} pairs in a small FIFO.
- Presents the head entry to the datapath, honours StallF, and flushes on branch/PC-write redirects.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'hE1A0_0000, value driven on InstrF when the queue is empty (MOV r0,r0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- StallF  input  1  hazard unit stall; head is not consumed while high.
- Redirect  input  1  flush request (BranchTakenE | PCSrcW).
- RedirectPC  input  32  new fetch address, valid with Redirect.
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  32  word address of the request.
- IMemReady  input  1  memory completion; IMemRData valid in the same cycle.
- IMemRData  input  32  fetched instruction.
- InstrF  output  32  head instruction, or NOP_INSTR when empty.
- PCF  output  32  PC of head entry, or fetch PC when empty.
- InstrValidF  output  1  head entry valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch PC = RESET_PC; count = 0; pointers = 0; state = FETCH.
  - IMemReq = 0; InstrValidF = 0; InstrF = NOP_INSTR; PCF = RESET_PC.
  - Reset mid-request abandons the access. Memory is reset by the same system reset.
- States: FETCH and DRAIN.
- FETCH:
  - IMemReq = (count < DEPTH); IMemAddr = fetch PC.
  - Once asserted, IMemReq and IMemAddr hold stable until a cycle with IMemReady=1.
  - At most one request is outstanding. Issue only when count < DEPTH. Count never rises while the request is pending, so a response always has a free slot.
  - Completion (IMemReq & IMemReady & ~Redirect): push {fetch PC, IMemRData}; fetch PC += 4 (32-bit wrap-around, no flag).
- DRAIN:
  - IMemReq = 1 with the old address; the response is discarded when IMemReady=1.
  - Next state FETCH with fetch PC = latched redirect target.
- Redirect (highest priority):
  - Queue cleared (count = 0, pointers reset); no push and no pop that cycle.
  - Target PC latched.
  - If a request is pending and IMemReady=0: next state DRAIN.
  - Else (no request pending, or IMemReady=1 this cycle; that data is dropped): next state FETCH with fetch PC = RedirectPC.
  - Redirect while in DRAIN: overwrite latched target, stay in DRAIN.
- Pop: InstrValidF & ~StallF & ~Redirect advances the read pointer.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into an empty queue is visible on InstrF the next cycle (no bypass).
- Outputs:
  - InstrF and PCF are combinational reads of the head slot when count > 0.
  - InstrValidF = (count != 0).
- Latency:
  - Redirect in cycle N gives IMemReq with the new address in N+1 (no drain).
  - With zero-wait memory, the instruction is on InstrF in N+2.
  - Steady-state throughput with zero-wait memory and no stall: 1 instr/cycle.
- Full: IMemReq drops when count = DEPTH with nothing pending. It re-asserts the cycle after a pop makes count < DEPTH.

Decomposition:
- Shared package (ifetch_pkg):
  - state enumeration {FETCH, DRAIN}.
  - NOP_INSTR default constant.
  - WORD_BYTES = 4.
- One sub-module: fetch_fifo, DEPTH x 64-bit storage.
  - Ports: push, pop, clear, din {pc, instr}, dout, count.
  - Pointer width $clog2(DEPTH); count width $clog2(DEPTH)+1.
  - Asynchronous active-low reset.
- ifetch_queue holds the FSM, fetch PC, redirect target and the handshake.

Test Plan:
- Reset release, zero-wait memory returning addr-as-data, StallF=0 -> IMemAddr 0x0,0x4,0x8… on consecutive cycles; InstrF=0x0 with PCF=0x0 first valid at cycle 2, then one per cycle.
- StallF held high 10 cycles -> queue fills to 4 (PCs 0x0–0xC); IMemReq drops; InstrF holds PC 0x0. StallF low -> IMemReq re-asserts one cycle after the first pop; no entry lost or duplicated.
- 3-wait-state memory, Redirect to 0x100 one cycle after a request to 0x8 -> IMemAddr stays 0x8 until IMemReady (data discarded), then 0x100. First valid InstrF has PCF=0x100.
- Redirect asserted in the same cycle as IMemReady for 0x10 -> 0x10 never enqueued; next IMemAddr = RedirectPC; InstrValidF=0 the next cycle.
- Two Redirects during DRAIN (0x200 then 0x300) -> fetch resumes at 0x300 only.
- Fetch PC at 0xFFFF_FFFC -> next IMemAddr 0x0000_0000. Reset asserted mid-request -> IMemReq=0 and InstrF=NOP_INSTR immediately (asynchronous).
